// File: rtl/neuron_accum.sv
// neuron_accum: accumulates N_TERMS signed partial sums, adds bias, shifts, saturates, optional ReLU (NEURON_RELU_EN); ports clk, rst_n, in_valid/in_ready/in_sum, bias, out_valid/out_ready/out_data, busy
module neuron_accum #(
  parameter int IN_W    = 18,
  parameter int N_TERMS = 16,
  parameter int BIAS_W  = 16,
  parameter int ACC_W   = 24,
  parameter int SHIFT   = 0,
  parameter int OUT_W   = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [IN_W-1:0]   in_sum,
  input  logic [BIAS_W-1:0] bias,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [OUT_W-1:0]  out_data,
  output logic              busy
);
  localparam int CNT_W = $clog2(N_TERMS + 1);
  localparam int EXT_W = (ACC_W > OUT_W ? ACC_W : OUT_W) + 1;
  localparam logic [1:0] IDLE = 2'd0, ACCUM = 2'd1, BIAS = 2'd2, OUT = 2'd3;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(N_TERMS - 1);
  logic [1:0] state_q, state_d;
  logic signed [ACC_W-1:0] acc_q, acc_d, term, total, shifted;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic out_valid_q, out_valid_d;
  logic [OUT_W-1:0] out_data_q, out_data_d, clip, act;
  logic signed [EXT_W-1:0] wide, sat_max, sat_min;
  logic take;
  assign in_ready  = state_q == IDLE || state_q == ACCUM;
  assign busy      = state_q != IDLE;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign take      = in_valid && in_ready;
  assign term      = {{(ACC_W-IN_W){in_sum[IN_W-1]}}, in_sum};
  assign total     = acc_q + {{(ACC_W-BIAS_W){bias[BIAS_W-1]}}, bias};
  assign shifted   = total >>> SHIFT;
  assign wide      = {{(EXT_W-ACC_W){shifted[ACC_W-1]}}, shifted};
  assign sat_max   = {{(EXT_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  assign sat_min   = ~sat_max;
  assign clip      = wide > sat_max ? {1'b0, {(OUT_W-1){1'b1}}} :
                     wide < sat_min ? {1'b1, {(OUT_W-1){1'b0}}} : wide[OUT_W-1:0];
`ifdef NEURON_RELU_EN
  assign act = wide[EXT_W-1] ? '0 : clip;
`else
  assign act = clip;
`endif
  // acc is zero whenever IDLE, so the first term needs no separate load path
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    if (take) begin
      acc_d   = acc_q + term;
      cnt_d   = cnt_q + 1'b1;
      state_d = cnt_q == LAST ? BIAS : ACCUM;
    end
    if (state_q == BIAS) begin
      out_data_d  = act;
      out_valid_d = 1'b1;
      state_d     = OUT;
    end
    if (state_q == OUT && out_ready) begin
      out_valid_d = 1'b0;
      acc_d       = '0;
      cnt_d       = '0;
      state_d     = IDLE;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end
endmodule

// File: tb/tb_neuron_accum.sv
// tb_neuron_accum: directed checks of neuron_accum with N_TERMS=4 at SHIFT=0 and SHIFT=4
module tb_neuron_accum;
  logic clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [17:0] in_sum = '0;
  logic [15:0] bias = '0;
  logic rdy0, rdy4, ov0, ov4, busy0, busy4;
  logic [15:0] od0, od4;
  int errs = 0, checks = 0;
  always #5 clk = ~clk;
  neuron_accum #(.N_TERMS(4), .SHIFT(0)) u0 (.clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy0),
    .in_sum(in_sum), .bias(bias), .out_valid(ov0), .out_ready(out_ready), .out_data(od0), .busy(busy0));
  neuron_accum #(.N_TERMS(4), .SHIFT(4)) u4 (.clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy4),
    .in_sum(in_sum), .bias(bias), .out_valid(ov4), .out_ready(out_ready), .out_data(od4), .busy(busy4));
  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic push(input int v);
    int n = 0;
    while (!rdy0 && n < 20) begin @(negedge clk); n++; end
    if (!rdy0) check("push_timeout", 0, 1);
    in_sum = 18'(v);
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
  endtask
  task automatic wait_out();
    int n = 0;
    while (!ov0 && n < 20) begin @(negedge clk); n++; end
    if (!ov0) check("out_timeout", 0, 1);
  endtask
  task automatic take_out(input string tag, input int e0, input int e4);
    wait_out();
    check({tag, "_d0"}, $signed(od0), e0);
    check({tag, "_d4"}, $signed(od4), e4);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask
  task automatic frame(input string tag, input int a, input int b, input int c, input int d,
                       input int bs, input int e0, input int e4);
    bias = 16'(bs);
    push(a); push(b); push(c); push(d);
    take_out(tag, e0, e4);
  endtask
  int vpat[7] = '{1, 0, 0, 1, 0, 1, 1};
  int held, k;
  initial begin
    @(negedge clk);
    check("rst_ready", rdy0, 1);
    check("rst_valid", ov0, 0);
    check("rst_data", od0, 0);
    check("rst_busy", busy0, 0);
    rst_n = 1'b1;
    @(negedge clk);
    bias = 16'd40;
    push(100); push(200); push(-50); push(10);
    check("lat_e_valid", ov0, 0);
    check("lat_e_busy", busy0, 1);
    check("lat_e_ready", rdy0, 0);
    @(negedge clk);
    check("lat_e1_valid", ov0, 1);
    take_out("basic", 300, 18);
    frame("sat_pos", 131071, 131071, 131071, 131071, 0, 32767, 32767);
`ifdef NEURON_RELU_EN
    frame("sat_neg", -131072, -131072, -131072, -131072, 0, 0, 0);
    frame("neg", -1000, -1000, -1000, -1000, 0, 0, 0);
    frame("m17", -17, 0, 0, 0, 0, 0, 0);
`else
    frame("sat_neg", -131072, -131072, -131072, -131072, 0, -32768, -32768);
    frame("neg", -1000, -1000, -1000, -1000, 0, -4000, -250);
    frame("m17", -17, 0, 0, 0, 0, -17, -2);
`endif
    frame("p17", 17, 0, 0, 0, 0, 17, 1);
    bias = -16'sd2;
    push(5); push(6); push(7); push(8);
    wait_out();
    check("bp_first", $signed(od0), 24);
    held = $signed(od0);
    in_valid = 1'b1;
    in_sum = 18'd77;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_valid", ov0, 1);
      check("bp_data", $signed(od0), held);
      check("bp_ready", rdy0, 0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_rel_valid", ov0, 0);
    check("bp_rel_ready", rdy0, 1);
    check("bp_rel_busy", busy0, 0);
    in_valid = 1'b0;
    out_ready = 1'b0;
    bias = 16'd3;
    k = 0;
    for (int i = 0; i < 7; i++) begin
      in_valid = vpat[i][0];
      in_sum = 18'(k + 1);
      @(negedge clk);
      if (vpat[i] == 1) k++;
    end
    in_valid = 1'b0;
    take_out("bubble", 13, 0);
    bias = 16'd0;
    push(500); push(500);
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", busy0, 0);
    check("mid_rst_ready", rdy0, 1);
    @(negedge clk);
    rst_n = 1'b1;
    frame("post_rst", 1, 1, 1, 1, 0, 4, 0);
    push(9); push(9); push(9); push(9);
    wait_out();
    check("out_rst_pre", ov0, 1);
    #1 rst_n = 1'b0;
    #1;
    check("out_rst_valid", ov0, 0);
    check("out_rst_data", od0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    frame("final", 2, 2, 2, 2, 0, 8, 0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
